// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
module cache_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        hit,
    output logic        err,
    output logic        stall,
    output logic [7:0]  arr_index,
    output logic [3:0]  arr_data_we,
    output logic [15:0] arr_data_in,
    input  logic [63:0] arr_data_out,
    output logic        arr_tag_we,
    output logic [4:0]  arr_tag_in,
    output logic        arr_valid_in,
    input  logic [4:0]  arr_tag_out,
    input  logic        arr_valid_out,
    output logic        arr_dirty_we,
    output logic        arr_dirty_in,
    input  logic        arr_dirty_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_CMP, S_WB, S_FILL, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_addr, r_wdata, r_data_out;
    logic        r_rd, r_wr, r_err, r_miss;
    logic [4:0]  r_vtag;
    logic [1:0]  r_cnt;

    logic [4:0]  w_tag;
    logic [7:0]  w_index;
    logic [1:0]  w_word;
    logic        w_lookup_hit;
    logic [15:0] w_bank_word, w_bank_cnt;

    assign w_tag        = r_addr[15:11];
    assign w_index      = r_addr[10:3];
    assign w_word       = r_addr[2:1];
    assign w_lookup_hit = arr_valid_out && (arr_tag_out == w_tag);
    assign w_bank_word  = arr_data_out[{w_word, 4'b0000} +: 16];
    assign w_bank_cnt   = arr_data_out[{r_cnt, 4'b0000} +: 16];
    assign data_out     = r_data_out;
    assign stall        = (r_state != S_IDLE);
    assign arr_index    = w_index;

    always_comb begin
        w_next       = r_state;
        done         = 1'b0;
        hit          = 1'b0;
        err          = 1'b0;
        arr_data_we  = 4'b0000;
        arr_data_in  = 16'h0000;
        arr_tag_we   = 1'b0;
        arr_tag_in   = 5'd0;
        arr_valid_in = 1'b0;
        arr_dirty_we = 1'b0;
        arr_dirty_in = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (rd || wr)
                    w_next = ((rd && wr) || addr[0]) ? S_DONE : S_CMP;
            end
            S_CMP: begin
                if (w_lookup_hit) begin
                    if (r_wr) begin
                        arr_data_we  = 4'b0001 << w_word;
                        arr_data_in  = r_wdata;
                        arr_dirty_we = 1'b1;
                        arr_dirty_in = 1'b1;
                    end
                    w_next = S_DONE;
                end else begin
                    w_next = (arr_valid_out && arr_dirty_out) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_vtag, w_index, r_cnt, 1'b0};
                mem_wdata = w_bank_cnt;
                if (mem_ack && r_cnt == 2'd3)
                    w_next = S_FILL;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_index, r_cnt, 1'b0};
                if (mem_ack) begin
                    arr_data_we = 4'b0001 << r_cnt;
                    arr_data_in = mem_rdata;
                    // Tag/valid land only with the last word so a cut-short fill stays invalid
                    if (r_cnt == 2'd3) begin
                        arr_tag_we   = 1'b1;
                        arr_tag_in   = w_tag;
                        arr_valid_in = 1'b1;
                        arr_dirty_we = 1'b1;
                        arr_dirty_in = 1'b0;
                        w_next       = S_CMP;
                    end
                end
            end
            S_DONE: begin
                done   = 1'b1;
                hit    = !r_miss;
                err    = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_data_out <= 16'h0000;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            r_miss     <= 1'b0;
            r_vtag     <= 5'd0;
            r_cnt      <= 2'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (rd || wr) begin
                        r_rd    <= rd;
                        r_wr    <= wr;
                        r_addr  <= addr;
                        r_wdata <= data_in;
                        r_err   <= (rd && wr) || addr[0];
                    end
                end
                S_CMP: begin
                    if (w_lookup_hit) begin
                        if (r_rd)
                            r_data_out <= w_bank_word;
                    end else begin
                        r_cnt <= 2'd0;
                        if (arr_valid_out && arr_dirty_out)
                            r_vtag <= arr_tag_out;
                    end
                end
                S_WB: begin
                    if (mem_ack)
                        r_cnt <= (r_cnt == 2'd3) ? 2'd0 : r_cnt + 2'd1;
                end
                S_FILL: begin
                    if (mem_ack) begin
                        if (r_cnt == 2'd3)
                            r_miss <= 1'b1;
                        else
                            r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_DONE: r_miss <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [15:0] addr = 16'h0, data_in = 16'h0;
    logic [15:0] data_out;
    logic        done, hit, err, stall;
    logic [7:0]  arr_index;
    logic [3:0]  arr_data_we;
    logic [15:0] arr_data_in;
    logic [63:0] arr_data_out;
    logic        arr_tag_we, arr_valid_in, arr_dirty_we, arr_dirty_in;
    logic [4:0]  arr_tag_in, arr_tag_out;
    logic        arr_valid_out, arr_dirty_out;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    int n_cmp = 0, n_bad = 0;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .done(done), .hit(hit), .err(err), .stall(stall),
        .arr_index(arr_index), .arr_data_we(arr_data_we), .arr_data_in(arr_data_in),
        .arr_data_out(arr_data_out), .arr_tag_we(arr_tag_we), .arr_tag_in(arr_tag_in),
        .arr_valid_in(arr_valid_in), .arr_tag_out(arr_tag_out), .arr_valid_out(arr_valid_out),
        .arr_dirty_we(arr_dirty_we), .arr_dirty_in(arr_dirty_in), .arr_dirty_out(arr_dirty_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Cache arrays: reads return 0 in any cycle that writes
    logic [63:0] m_data  [256];
    logic [4:0]  m_tag   [256];
    logic        m_valid [256];
    logic        m_dirty [256];
    logic        any_we;

    assign any_we        = (|arr_data_we) || arr_tag_we || arr_dirty_we;
    assign arr_data_out  = any_we ? 64'h0 : m_data[arr_index];
    assign arr_tag_out   = m_tag[arr_index];
    assign arr_valid_out = m_valid[arr_index];
    assign arr_dirty_out = m_dirty[arr_index];

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (arr_data_we[b]) m_data[arr_index][16*b +: 16] <= arr_data_in;
        if (arr_tag_we) begin
            m_tag[arr_index]   <= arr_tag_in;
            m_valid[arr_index] <= arr_valid_in;
        end
        if (arr_dirty_we) m_dirty[arr_index] <= arr_dirty_in;
    end

    // Backing memory: one wait cycle then a one-cycle ack, logged
    logic [15:0] bm [32768];
    logic [15:0] log_addr[$], log_wdata[$];
    logic        log_we[$];
    int          mlat = 0;
    int          n_memreq = 0, n_arrwr = 0;

    always @(negedge clk) begin
        if (mem_req) n_memreq++;
        if (any_we) n_arrwr++;
        if (rst || mem_ack) begin
            mem_ack = 1'b0;
            mlat = 0;
        end else if (mem_req) begin
            if (mlat == 1) begin
                mem_ack = 1'b1;
                mem_rdata = bm[mem_addr[15:1]];
                if (mem_we) bm[mem_addr[15:1]] = mem_wdata;
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wdata.push_back(mem_wdata);
            end else begin
                mlat++;
            end
        end
    end

    logic        s_done, s_hit, s_err;
    logic [15:0] s_data;
    int          s_lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic t_rd, input logic t_wr, input logic [15:0] t_addr,
                          input logic [15:0] t_data);
        @(negedge clk);
        rd = t_rd; wr = t_wr; addr = t_addr; data_in = t_data;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        s_lat = 1;
        while (!done && s_lat < 300) begin
            @(negedge clk);
            s_lat++;
        end
        s_done = done; s_hit = hit; s_err = err; s_data = data_out;
        check("done_seen", {31'd0, s_done}, 32'd1);
    endtask

    int base, snap_req, snap_wr;

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_data[i] = 64'h0; m_tag[i] = 5'd0; m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 32768; i++) bm[i] = 16'hA000 + 16'(i % 4);

        repeat (2) @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'h0);
        check("rst_strobes", {28'd0, arr_data_we} | {31'd0, arr_tag_we} | {31'd0, arr_dirty_we}, 32'd0);
        rst = 1'b0;

        // Cold read miss
        do_req(1'b1, 1'b0, 16'h1234, 16'h0);
        check("cold_nlog", log_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("cold_addr", {16'd0, log_addr[i]}, 32'h1230 + 32'(2 * i));
            check("cold_we", {31'd0, log_we[i]}, 32'd0);
        end
        check("cold_hit", {31'd0, s_hit}, 32'd0);
        check("cold_err", {31'd0, s_err}, 32'd0);
        check("cold_data", {16'd0, s_data}, 32'hA002);

        // Repeat read hits with 2-cycle latency and no memory traffic
        snap_req = n_memreq;
        do_req(1'b1, 1'b0, 16'h1234, 16'h0);
        check("hit_lat", s_lat, 32'd2);
        check("hit_hit", {31'd0, s_hit}, 32'd1);
        check("hit_data", {16'd0, s_data}, 32'hA002);
        check("hit_nomem", n_memreq - snap_req, 32'd0);

        // Write hit then read back
        do_req(1'b0, 1'b1, 16'h1236, 16'hBEEF);
        check("wr_hit", {31'd0, s_hit}, 32'd1);
        check("wr_dirty", {31'd0, m_dirty[8'h46]}, 32'd1);
        do_req(1'b1, 1'b0, 16'h1236, 16'h0);
        check("rdback_hit", {31'd0, s_hit}, 32'd1);
        check("rdback_data", {16'd0, s_data}, 32'hBEEF);

        // Conflict miss on dirty line: write-back then fill
        base = log_addr.size();
        do_req(1'b1, 1'b0, 16'h9234, 16'h0);
        check("evict_nlog", log_addr.size() - base, 32'd8);
        for (int i = 0; i < 4; i++) begin
            check("wb_addr", {16'd0, log_addr[base + i]}, 32'h1230 + 32'(2 * i));
            check("wb_we", {31'd0, log_we[base + i]}, 32'd1);
            check("fill_addr", {16'd0, log_addr[base + 4 + i]}, 32'h9230 + 32'(2 * i));
            check("fill_we", {31'd0, log_we[base + 4 + i]}, 32'd0);
        end
        check("wb_w0", {16'd0, log_wdata[base]}, 32'hA000);
        check("wb_w2", {16'd0, log_wdata[base + 2]}, 32'hA002);
        check("wb_w3", {16'd0, log_wdata[base + 3]}, 32'hBEEF);
        check("evict_hit", {31'd0, s_hit}, 32'd0);
        check("evict_data", {16'd0, s_data}, 32'hA002);
        check("evict_clean", {31'd0, m_dirty[8'h46]}, 32'd0);
        check("evict_tag", {27'd0, m_tag[8'h46]}, 32'h12);

        // Rejected requests touch nothing
        snap_req = n_memreq; snap_wr = n_arrwr;
        do_req(1'b1, 1'b0, 16'h0001, 16'h0);
        check("odd_err", {31'd0, s_err}, 32'd1);
        do_req(1'b1, 1'b1, 16'h1234, 16'h5555);
        check("rdwr_err", {31'd0, s_err}, 32'd1);
        check("err_nomem", n_memreq - snap_req, 32'd0);
        check("err_noarr", n_arrwr - snap_wr, 32'd0);

        // Reset in the middle of a fill at cnt=2
        base = log_addr.size();
        @(negedge clk);
        rd = 1'b1; addr = 16'h2238;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        for (int i = 0; i < 300 && log_addr.size() < base + 2; i++) @(negedge clk);
        check("pre_rst_fills", log_addr.size() - base, 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_async_stall", {31'd0, stall}, 32'd0);
        check("rst_line_invalid", {31'd0, m_valid[8'h47]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b1, 1'b0, 16'h2238, 16'h0);
        check("rerd_hit", {31'd0, s_hit}, 32'd0);
        check("rerd_data", {16'd0, s_data}, 32'hA000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
